// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU opcode encoding, forwarding select
// codes and default datapath widths.
package riscv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_BEQ  = 4'b1001,
    ALU_BNE  = 4'b1010,
    ALU_BLT  = 4'b1011,
    ALU_BGE  = 4'b1100,
    ALU_JAL  = 4'b1101,
    ALU_JALR = 4'b1110
  } alu_sel_e;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding mux: picks EX/MEM, then MEM/WB, then the register
// file value. x0 is never forwarded.
module fwd_mux #(
  parameter int XLEN      = riscv_pkg::DEF_XLEN,
  parameter int RA_W      = riscv_pkg::DEF_RA_W,
  parameter bit FWD_MEMWB = 1'b1
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_reg_wr_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_reg_wr_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] val_o,
  output logic [1:0]      sel_o
);

  always_comb begin
    sel_o = riscv_pkg::FWD_REG;
    val_o = reg_data_i;
    if (rs_i != '0) begin
      if (exmem_reg_wr_i && (exmem_rd_i == rs_i)) begin
        sel_o = riscv_pkg::FWD_EXMEM;
        val_o = exmem_result_i;
      end else if (FWD_MEMWB && memwb_reg_wr_i && (memwb_rd_i == rs_i)) begin
        sel_o = riscv_pkg::FWD_MEMWB;
        val_o = memwb_result_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection; drives the ALU operands and opcode directly.
module id_ex_stage #(
  parameter int XLEN      = riscv_pkg::DEF_XLEN,
  parameter int RA_W      = riscv_pkg::DEF_RA_W,
  parameter bit FWD_MEMWB = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [3:0]      id_ALU_sel,
  input  logic            id_srcA_pc,
  input  logic            id_srcB_imm,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic            id_reg_wr,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_reg_wr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_reg_wr,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            stall_id,
  output logic [XLEN-1:0] ALU_A,
  output logic [XLEN-1:0] ALU_B,
  output logic [3:0]      ALU_sel,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_reg_wr
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [3:0]      alu_sel;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d;
  logic     load_use;

  assign load_use = ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // A flush kills the younger instruction in ID, so it need not wait.
  assign stall_id = ex_hold || (load_use && !ex_flush);

  always_comb begin
    ex_d = ex_q;
    if (!ex_hold) begin
      if (ex_flush || load_use) begin
        ex_d         = '0;
        ex_d.alu_sel = riscv_pkg::ALU_ADD;
      end else begin
        ex_d.valid     = id_valid;
        ex_d.pc        = id_pc;
        // Link value is captured with the PC so reset leaves it at 0.
        ex_d.pc4       = id_pc + XLEN'(4);
        ex_d.rs1_data  = id_rs1_data;
        ex_d.rs2_data  = id_rs2_data;
        ex_d.imm       = id_imm;
        ex_d.rs1       = id_rs1;
        ex_d.rs2       = id_rs2;
        ex_d.rd        = id_rd;
        ex_d.alu_sel   = id_ALU_sel;
        ex_d.src_a_pc  = id_srcA_pc;
        ex_d.src_b_imm = id_srcB_imm;
        ex_d.mem_rd    = id_mem_rd;
        ex_d.mem_wr    = id_mem_wr;
        ex_d.reg_wr    = id_reg_wr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic [1:0]      sel_rs1, sel_rs2;
  logic [3:0]      unused_fwd_sel;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_MEMWB(FWD_MEMWB)) u_fwd_rs1 (
    .rs_i(ex_q.rs1), .reg_data_i(ex_q.rs1_data),
    .exmem_rd_i(exmem_rd), .exmem_reg_wr_i(exmem_reg_wr), .exmem_result_i(exmem_result),
    .memwb_rd_i(memwb_rd), .memwb_reg_wr_i(memwb_reg_wr), .memwb_result_i(memwb_result),
    .val_o(fwd_rs1), .sel_o(sel_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_MEMWB(FWD_MEMWB)) u_fwd_rs2 (
    .rs_i(ex_q.rs2), .reg_data_i(ex_q.rs2_data),
    .exmem_rd_i(exmem_rd), .exmem_reg_wr_i(exmem_reg_wr), .exmem_result_i(exmem_result),
    .memwb_rd_i(memwb_rd), .memwb_reg_wr_i(memwb_reg_wr), .memwb_result_i(memwb_result),
    .val_o(fwd_rs2), .sel_o(sel_rs2)
  );

  // Select codes are kept for debug visibility only.
  assign unused_fwd_sel = {sel_rs1, sel_rs2};

  assign ALU_A         = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
  assign ALU_B         = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ALU_sel       = ex_q.alu_sel;
  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_pc4        = ex_q.pc4;
  assign ex_rd         = ex_q.rd;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_reg_wr     = ex_q.reg_wr;

endmodule
